// File: rtl/seg_disp_arbiter_if.sv
// Bus bundle between the debug-tap requesters and the seven-segment display arbiter.
// The lock input is present only when SEG_ARB_LOCK_EN is defined.
interface seg_disp_arbiter_if #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned DATA_W  = 20
);
  logic [NUM_SRC-1:0]        req;
  logic [NUM_SRC*DATA_W-1:0] data_in;
  logic [NUM_SRC-1:0]        grant;
  logic [DATA_W-1:0]         disp_data;
  logic [2:0]                disp_src;
  logic                      disp_update;
  logic                      disp_ovf;
  logic                      busy;
`ifdef SEG_ARB_LOCK_EN
  logic                      lock;

  modport master (
    output req, data_in, lock,
    input  grant, disp_data, disp_src, disp_update, disp_ovf, busy
  );
  modport slave (
    input  req, data_in, lock,
    output grant, disp_data, disp_src, disp_update, disp_ovf, busy
  );
`else
  modport master (
    output req, data_in,
    input  grant, disp_data, disp_src, disp_update, disp_ovf, busy
  );
  modport slave (
    input  req, data_in,
    output grant, disp_data, disp_src, disp_update, disp_ovf, busy
  );
`endif
endinterface

// File: rtl/seg_disp_arbiter.sv
// Round-robin time-slice arbiter sharing one 6-digit seven-segment driver between requesters.
// Define SEG_ARB_LOCK_EN to add a lock input that freezes the current dwell.
module seg_disp_arbiter #(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned DATA_W      = 20,
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned DISP_MAX    = 999999
) (
  input logic              clk,
  input logic              resetn,
  seg_disp_arbiter_if.slave bus
);
  localparam int unsigned TIMER_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned MAX_SRC = 8;
  localparam logic [DATA_W-1:0]  MAX_V      = DATA_W'(DISP_MAX);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, SWITCH = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [2:0]           last_q, last_d;
  logic [NUM_SRC-1:0]   grant_q, grant_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [2:0]           src_q, src_d;
  logic                 upd_q, upd_d;
  logic                 ovf_q, ovf_d;
  logic                 busy_q;

  logic [DATA_W-1:0]    src_val [MAX_SRC];
  logic [MAX_SRC-1:0]   req_pad;
  logic [NUM_SRC-1:0]   rot;
  logic [3:0]           sel_off;
  logic [4:0]           sel_sum;
  logic [2:0]           sel_idx;
  logic                 sel_found;
  logic [DATA_W-1:0]    load_val;
  logic                 lock_on;

`ifdef SEG_ARB_LOCK_EN
  assign lock_on = bus.lock;
`else
  assign lock_on = 1'b0;
`endif

  // Pad sources to 8 entries so a 3-bit index is always in range.
  for (genvar g = 0; g < MAX_SRC; g++) begin : g_src
    if (g < NUM_SRC) begin : g_used
      assign src_val[g] = bus.data_in[g*DATA_W +: DATA_W];
    end else begin : g_pad
      assign src_val[g] = '0;
    end
  end
  assign req_pad = MAX_SRC'(bus.req);

  // Rotate requests so bit 0 is the source after last; lowest set bit wins.
  assign rot = NUM_SRC'({bus.req, bus.req} >> (4'(last_q) + 4'd1));

  always_comb begin
    sel_off = '0;
    for (int j = NUM_SRC - 1; j >= 0; j--) begin
      if (rot[j]) sel_off = 4'(j);
    end
    sel_found = |bus.req;
    sel_sum   = 5'(last_q) + 5'(sel_off) + 5'd1;
    sel_idx   = (sel_sum >= 5'(NUM_SRC)) ? 3'(sel_sum - 5'(NUM_SRC)) : 3'(sel_sum);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      timer_q <= '0;
      last_q  <= 3'(NUM_SRC - 1);
      grant_q <= '0;
      data_q  <= '0;
      src_q   <= '0;
      upd_q   <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      src_q   <= src_d;
      upd_q   <= upd_d;
      ovf_q   <= ovf_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // Next-state logic; a dropped request ends the slot even while locked.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HOLD: begin
        if (!req_pad[src_q] || (timer_q == '0 && !lock_on)) state_d = SWITCH;
      end
      default: state_d = sel_found ? HOLD : IDLE;
    endcase
  end

  // Output/datapath next values.
  always_comb begin
    grant_d  = '0;
    data_d   = data_q;
    src_d    = src_q;
    upd_d    = 1'b0;
    ovf_d    = ovf_q;
    timer_d  = timer_q;
    last_d   = last_q;
    load_val = src_val[sel_idx];
    case (state_q)
      HOLD: begin
        load_val = src_val[src_q];
        data_d   = (load_val > MAX_V) ? MAX_V : load_val;
        ovf_d    = (load_val > MAX_V);
        if (state_d == HOLD) grant_d = grant_q;
        if (!lock_on && timer_q != '0) timer_d = timer_q - TIMER_W'(1);
      end
      default: begin
        if (sel_found) begin
          grant_d = NUM_SRC'(1) << sel_idx;
          data_d  = (load_val > MAX_V) ? MAX_V : load_val;
          ovf_d   = (load_val > MAX_V);
          src_d   = sel_idx;
          last_d  = sel_idx;
          timer_d = TIMER_LOAD;
          upd_d   = 1'b1;
        end
      end
    endcase
  end

  assign bus.grant       = grant_q;
  assign bus.disp_data   = data_q;
  assign bus.disp_src    = src_q;
  assign bus.disp_update = upd_q;
  assign bus.disp_ovf    = ovf_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Self-checking bench for seg_disp_arbiter: slot-level reference model plus directed scenarios.
// Lock scenario is compiled in when SEG_ARB_LOCK_EN is defined.
module tb_seg_disp_arbiter;
  localparam int unsigned NS = 4;
  localparam int unsigned DW = 20;
  localparam int unsigned HC = 4;
  localparam logic [19:0] DMAX = 20'd999999;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  req_tb = 4'd0;
  logic [19:0] src_data [4];
  logic        lock_m = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic        prev_upd = 1'b0;

  logic [3:0] exp_g1 [6]  = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd1};
  logic       exp_u1 [6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [3:0] exp_g2 [21] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd2, 4'd2, 4'd2, 4'd2, 4'd0,
                              4'd4, 4'd4, 4'd4, 4'd4, 4'd0, 4'd8, 4'd8, 4'd8, 4'd8, 4'd0, 4'd1};
  logic [2:0] exp_s2 [21] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1,
                              3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd0};

  seg_disp_arbiter_if #(.NUM_SRC(NS), .DATA_W(DW)) bus ();

  seg_disp_arbiter #(
    .NUM_SRC(NS), .DATA_W(DW), .HOLD_CYCLES(HC), .DISP_MAX(999999)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.req     = req_tb;
    bus.data_in = {src_data[3], src_data[2], src_data[1], src_data[0]};
  end
`ifdef SEG_ARB_LOCK_EN
  always_comb bus.lock = lock_m;
`endif

  // Reference model: who owns the display and for how many cycles so far.
  logic        m_hold = 1'b0;
  logic [1:0]  m_own = 2'd0;
  logic [1:0]  m_last = 2'd3;
  int unsigned m_used = 0;
  logic [3:0]  m_grant = 4'd0;
  logic [19:0] m_data = 20'd0;
  logic [2:0]  m_src = 3'd0;
  logic        m_upd = 1'b0;
  logic        m_ovf = 1'b0;
  logic        m_busy = 1'b0;

  always @(posedge clk) begin : model
    logic [1:0]  pick;
    logic [19:0] v;
    if (!resetn) begin
      m_hold = 1'b0; m_own = 2'd0; m_last = 2'd3; m_used = 0;
      m_grant = 4'd0; m_data = 20'd0; m_src = 3'd0;
      m_upd = 1'b0; m_ovf = 1'b0; m_busy = 1'b0;
    end else if (m_hold) begin
      m_upd  = 1'b0;
      v      = src_data[m_own];
      m_data = (v > DMAX) ? DMAX : v;
      m_ovf  = (v > DMAX);
      m_busy = 1'b1;
      if (!req_tb[m_own] || (m_used >= HC && !lock_m)) begin
        m_hold  = 1'b0;
        m_grant = 4'd0;
      end else if (!lock_m) begin
        m_used++;
      end
    end else begin
      m_upd   = 1'b0;
      m_grant = 4'd0;
      m_busy  = 1'b0;
      if (req_tb != 4'd0) begin
        pick = m_last;
        for (int k = 4; k >= 1; k--) begin
          if (req_tb[m_last + 2'(k)]) pick = m_last + 2'(k);
        end
        v       = src_data[pick];
        m_hold  = 1'b1;
        m_own   = pick;
        m_last  = pick;
        m_used  = 1;
        m_grant = 4'd1 << pick;
        m_src   = 3'(pick);
        m_data  = (v > DMAX) ? DMAX : v;
        m_ovf   = (v > DMAX);
        m_upd   = 1'b1;
        m_busy  = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, plus invariants.
  always @(negedge clk) begin
    check("grant",       32'(bus.grant),       32'(m_grant));
    check("disp_data",   32'(bus.disp_data),   32'(m_data));
    check("disp_src",    32'(bus.disp_src),    32'(m_src));
    check("disp_update", 32'(bus.disp_update), 32'(m_upd));
    check("disp_ovf",    32'(bus.disp_ovf),    32'(m_ovf));
    check("busy",        32'(bus.busy),        32'(m_busy));
    check("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
    check("upd_back_to_back", 32'(bus.disp_update & prev_upd), 32'd0);
    prev_upd = bus.disp_update;
  end

  task automatic wait_grant(input logic [3:0] g, input string name);
    int n = 0;
    while (bus.grant !== g && n < 12) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.grant), 32'(g));
  endtask

  initial begin
    for (int i = 0; i < 4; i++) src_data[i] = 20'd0;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_data",  32'(bus.disp_data), 32'd0);
    check("rst_busy",  32'(bus.busy), 32'd0);

    // Lone requester is re-granted every HC+1 cycles.
    src_data[0] = 20'd123456;
    src_data[3] = 20'd314159;
    resetn = 1'b1;
    req_tb = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("t1_grant", 32'(bus.grant), 32'(exp_g1[c]));
      check("t1_upd", 32'(bus.disp_update), 32'(exp_u1[c]));
      if (c == 0) check("t1_data", 32'(bus.disp_data), 32'd123456);
    end

    // Reset, then all four request: full rotation.
    resetn = 1'b0;
    req_tb = 4'b0000;
    @(negedge clk);
    check("t2_rst_grant", 32'(bus.grant), 32'd0);
    check("t2_rst_data", 32'(bus.disp_data), 32'd0);
    resetn = 1'b1;
    req_tb = 4'b1111;
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      check("t2_grant", 32'(bus.grant), 32'(exp_g2[c]));
      check("t2_src", 32'(bus.disp_src), 32'(exp_s2[c]));
    end

    // Clamp and live tracking on source 1.
    src_data[1] = 20'hFFFFF;
    src_data[2] = 20'd777;
    wait_grant(4'b0010, "t3_wait_src1");
    check("t3_clamp_data", 32'(bus.disp_data), 32'd999999);
    check("t3_clamp_ovf", 32'(bus.disp_ovf), 32'd1);
    check("t3_src", 32'(bus.disp_src), 32'd1);
    src_data[1] = 20'd42;
    @(negedge clk);
    check("t3_live_data", 32'(bus.disp_data), 32'd42);
    check("t3_live_ovf", 32'(bus.disp_ovf), 32'd0);

    // Source 2 drops early with source 3 waiting, then idle retention.
    wait_grant(4'b0100, "t4_wait_src2");
    check("t4_data", 32'(bus.disp_data), 32'd777);
    @(negedge clk);
    req_tb = 4'b1000;
    @(negedge clk);
    check("t4_sw_grant", 32'(bus.grant), 32'd0);
    check("t4_sw_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("t4_g3_grant", 32'(bus.grant), 32'd8);
    check("t4_g3_src", 32'(bus.disp_src), 32'd3);
    check("t4_g3_upd", 32'(bus.disp_update), 32'd1);
    check("t4_g3_data", 32'(bus.disp_data), 32'd314159);
    src_data[2] = 20'd555;
    req_tb = 4'b0100;
    @(negedge clk);
    check("t4_sw2_grant", 32'(bus.grant), 32'd0);
    @(negedge clk);
    check("t4_g2_grant", 32'(bus.grant), 32'd4);
    check("t4_g2_data", 32'(bus.disp_data), 32'd555);
    req_tb = 4'b0000;
    @(negedge clk);
    check("t4_sw3_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("t4_idle_grant", 32'(bus.grant), 32'd0);
    check("t4_idle_busy", 32'(bus.busy), 32'd0);
    check("t4_idle_data", 32'(bus.disp_data), 32'd555);
    check("t4_idle_src", 32'(bus.disp_src), 32'd2);

    // Reset in the middle of source 3's slot.
    req_tb = 4'b1000;
    @(negedge clk);
    check("t5_grant3", 32'(bus.grant), 32'd8);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("t5_rst_grant", 32'(bus.grant), 32'd0);
    check("t5_rst_data", 32'(bus.disp_data), 32'd0);
    check("t5_rst_src", 32'(bus.disp_src), 32'd0);
    check("t5_rst_busy", 32'(bus.busy), 32'd0);
    check("t5_rst_ovf", 32'(bus.disp_ovf), 32'd0);
    resetn = 1'b1;
    req_tb = 4'b1111;
    @(negedge clk);
    check("t5_first_grant", 32'(bus.grant), 32'd1);

`ifdef SEG_ARB_LOCK_EN
    // Lock freezes source 1's dwell; release lets the remaining timer run out.
    wait_grant(4'b0010, "t6_wait_src1");
    lock_m = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("t6_locked_grant", 32'(bus.grant), 32'd2);
    end
    lock_m = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t6_tail_grant", 32'(bus.grant), 32'd2);
    end
    @(negedge clk);
    check("t6_sw_grant", 32'(bus.grant), 32'd0);
    @(negedge clk);
    check("t6_next_grant", 32'(bus.grant), 32'd4);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
